// File: rtl/combi_pkg.sv
// Shared decode-stage types and constants: immediate formats, NOP encoding, ARM PC index.
package combi_pkg;

  typedef enum logic [2:0] {
    IMM_I       = 3'd0,
    IMM_S       = 3'd1,
    IMM_B       = 3'd2,
    IMM_U       = 3'd3,
    IMM_J       = 3'd4,
    IMM_DP_ROT  = 3'd5,
    IMM_MEM12   = 3'd6,
    IMM_BR24    = 3'd7
  } imm_src_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [4:0]  ARM_PC_IDX = 5'd15;

  function automatic logic [31:0] ror32(input logic [31:0] val, input logic [4:0] sh);
    logic [63:0] dbl;
    dbl = {val, val} >> sh;
    return dbl[31:0];
  endfunction

endpackage

// File: rtl/stage_d_regfile.sv
// 32x32 register file: two combinational read ports with write-through, one write port.
// x0 reads as zero in RV mode; r15 reads as PC+8 in ARM mode (caller ties arm_rd low when ARM is off).
module regfile
  import combi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        arm_rd,
  input  logic [31:0] pc_plus8,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic        arm_wr,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic        wr_ok;

  // An RV write to x0 is dropped; ARM r0 is a real register.
  assign wr_ok = we && ((wa != 5'd0) || arm_wr);

  always_comb begin
    for (int i = 0; i < 32; i++) regs_d[i] = regs_q[i];
    if (wr_ok) regs_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
    end else begin
      for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
    end
  end

  function automatic logic [31:0] read_port(input logic [4:0] idx);
    logic [31:0] val;
    if (!arm_rd && (idx == 5'd0))              val = 32'h0;
    else if (arm_rd && (idx == ARM_PC_IDX))    val = pc_plus8;
    else if (wr_ok && (wa == idx))             val = wd;
    else                                       val = regs_q[idx];
    return val;
  endfunction

  always_comb begin
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
  end

endmodule

// File: rtl/stage_d.sv
// Decode stage: IF/ID pipeline register, register-field extraction, register file, immediate extender.
// Optional macro COMBI_ARM_EN enables ARM field decode, r15=PC+8 reads and ARM immediates (ImmSrcD 5..7).
module stage_d
  import combi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] RDD,
  input  logic [31:0] PCF,
  input  logic [31:0] PCPlus4F,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        armD,
  input  logic [2:0]  ImmSrcD,
  input  logic        RegWriteW,
  input  logic        armW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic [31:0] RD1D,
  output logic [31:0] RD2D,
  output logic [31:0] ImmExtD,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic [4:0]  RdD,
  output logic        ValidD
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  logic        arm_d_eff;
  logic        arm_w_eff;
  logic [31:0] pc_plus8;

`ifdef COMBI_ARM_EN
  assign arm_d_eff = armD;
  assign arm_w_eff = armW;
  assign pc_plus8  = pc_plus4_q + 32'd4;
`else
  logic unused_arm;
  assign unused_arm = armD ^ armW;
  assign arm_d_eff  = 1'b0;
  assign arm_w_eff  = 1'b0;
  assign pc_plus8   = 32'h0;
`endif

  // Flush wins over stall; stall holds everything.
  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (FlushD) begin
      instr_d    = NOP_INSTR;
      pc_d       = 32'h0;
      pc_plus4_d = 32'h0;
      valid_d    = 1'b0;
    end else if (!StallD) begin
      instr_d    = RDD;
      pc_d       = PCF;
      pc_plus4_d = PCPlus4F;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= 32'h0;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pc_q;
  assign PCPlus4D = pc_plus4_q;
  assign ValidD   = valid_q;

  always_comb begin
    Rs1D = instr_q[19:15];
    Rs2D = instr_q[24:20];
    RdD  = instr_q[11:7];
    if (arm_d_eff) begin
      Rs1D = {1'b0, instr_q[19:16]};
      Rs2D = {1'b0, instr_q[3:0]};
      RdD  = {1'b0, instr_q[15:12]};
    end
  end

  regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .ra1      (Rs1D),
    .ra2      (Rs2D),
    .arm_rd   (arm_d_eff),
    .pc_plus8 (pc_plus8),
    .we       (RegWriteW),
    .wa       (RdW),
    .wd       (ResultW),
    .arm_wr   (arm_w_eff),
    .rd1      (RD1D),
    .rd2      (RD2D)
  );

  always_comb begin
    ImmExtD = 32'h0;
    case (imm_src_e'(ImmSrcD))
      IMM_I: ImmExtD = {{20{instr_q[31]}}, instr_q[31:20]};
      IMM_S: ImmExtD = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      IMM_B: ImmExtD = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                        instr_q[11:8], 1'b0};
      IMM_U: ImmExtD = {instr_q[31:12], 12'h000};
      IMM_J: ImmExtD = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                        instr_q[30:21], 1'b0};
`ifdef COMBI_ARM_EN
      IMM_DP_ROT: ImmExtD = ror32({24'h0, instr_q[7:0]}, {instr_q[11:8], 1'b0});
      IMM_MEM12:  ImmExtD = {20'h0, instr_q[11:0]};
      IMM_BR24:   ImmExtD = {{6{instr_q[23]}}, instr_q[23:0], 2'b00};
`endif
      default: ImmExtD = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_stage_d.sv
// Directed bench for stage_d: IF/ID capture/stall/flush, regfile write-through and x0, immediates, reset.
module tb_stage_d;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] RDD, PCF, PCPlus4F;
  logic        StallD, FlushD, armD;
  logic [2:0]  ImmSrcD;
  logic        RegWriteW, armW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic [31:0] InstrD, PCD, PCPlus4D, RD1D, RD2D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        ValidD;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stage_d dut (
    .clk(clk), .rst(rst), .RDD(RDD), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .StallD(StallD), .FlushD(FlushD), .armD(armD), .ImmSrcD(ImmSrcD),
    .RegWriteW(RegWriteW), .armW(armW), .RdW(RdW), .ResultW(ResultW),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .RD1D(RD1D), .RD2D(RD2D),
    .ImmExtD(ImmExtD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ValidD(ValidD)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [31:0] pc);
    RDD = instr; PCF = pc; PCPlus4F = pc + 32'd4;
  endtask

  initial begin
    rst = 1'b1; RDD = 32'h0; PCF = 32'h0; PCPlus4F = 32'h0;
    StallD = 1'b0; FlushD = 1'b0; armD = 1'b0; ImmSrcD = 3'd0;
    RegWriteW = 1'b0; armW = 1'b0; RdW = 5'd0; ResultW = 32'h0;
    step(); step();
    check("rst_instr", InstrD, 32'h00000013);
    check("rst_pc", PCD, 32'h0);
    check("rst_pc4", PCPlus4D, 32'h0);
    check("rst_valid", {31'h0, ValidD}, 32'h0);

    // addi x1,x0,5 at 0x40
    rst = 1'b0;
    fetch(32'h00500093, 32'h40);
    step();
    check("addi_instr", InstrD, 32'h00500093);
    check("addi_pc", PCD, 32'h40);
    check("addi_pc4", PCPlus4D, 32'h44);
    check("addi_valid", {31'h0, ValidD}, 32'h1);
    check("addi_rs1", {27'h0, Rs1D}, 32'h0);
    check("addi_rd", {27'h0, RdD}, 32'h1);
    check("addi_imm", ImmExtD, 32'h5);
    check("addi_rd1", RD1D, 32'h0);

    // Stall for two cycles while fetch keeps changing
    StallD = 1'b1;
    fetch(32'h12345678, 32'h80); step();
    fetch(32'h9ABCDEF0, 32'h84); step();
    check("stall_instr", InstrD, 32'h00500093);
    check("stall_pc", PCD, 32'h40);
    check("stall_valid", {31'h0, ValidD}, 32'h1);

    // Flush beats stall
    FlushD = 1'b1; step();
    check("flush_instr", InstrD, 32'h00000013);
    check("flush_valid", {31'h0, ValidD}, 32'h0);
    check("flush_pc", PCD, 32'h0);
    check("flush_pc4", PCPlus4D, 32'h0);

    // add x5,x3,x4, then hold it and write x3 with bypass
    FlushD = 1'b0; StallD = 1'b0;
    fetch(32'h004182B3, 32'h50); step();
    check("add_rs1", {27'h0, Rs1D}, 32'd3);
    check("add_rs2", {27'h0, Rs2D}, 32'd4);
    check("add_rd", {27'h0, RdD}, 32'd5);
    check("add_rd1_init", RD1D, 32'h0);
    StallD = 1'b1;
    RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'hDEADBEEF; #1;
    check("wt_rd1", RD1D, 32'hDEADBEEF);
    check("wt_rd2_other", RD2D, 32'h0);
    step();
    RdW = 5'd4; ResultW = 32'h00001234; step();
    RegWriteW = 1'b0; #1;
    check("stored_rd1", RD1D, 32'hDEADBEEF);
    check("stored_rd2", RD2D, 32'h00001234);

    // RV write to x0 is dropped and x0 never bypasses
    StallD = 1'b0;
    fetch(32'h00000033, 32'h60);
    RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'hFFFF0000; armW = 1'b0;
    step();
    check("x0_during_write", RD1D, 32'h0);
    RegWriteW = 1'b0; step();
    check("x0_after_write", RD1D, 32'h0);

    // Immediates from beq offset -4
    fetch(32'hFE000EE3, 32'h70); step();
    ImmSrcD = 3'd2; #1; check("imm_b", ImmExtD, 32'hFFFFFFFC);
    ImmSrcD = 3'd1; #1; check("imm_s", ImmExtD, 32'hFFFFFFFD);
    ImmSrcD = 3'd0; #1; check("imm_i", ImmExtD, 32'hFFFFFFE0);
    ImmSrcD = 3'd3; #1; check("imm_u", ImmExtD, 32'hFE000000);
    // jal x0,+2048
    fetch(32'h0010006F, 32'h74); step();
    ImmSrcD = 3'd4; #1; check("imm_j", ImmExtD, 32'h00000800);

    // Write x15, then read it with an instruction whose rs1 field is 15
    RegWriteW = 1'b1; RdW = 5'd15; ResultW = 32'hCAFE0000;
    fetch(32'h00078013, 32'h78); step();
    RegWriteW = 1'b0;
`ifdef COMBI_ARM_EN
    // ARM: Rn=15 reads PC+8; immediates 5..7
    armD = 1'b1;
    fetch(32'hE28F04FF, 32'h100); step();
    check("arm_rs1", {27'h0, Rs1D}, 32'd15);
    check("arm_rs2", {27'h0, Rs2D}, 32'd15);
    check("arm_rd", {27'h0, RdD}, 32'd0);
    check("arm_pc8", RD1D, 32'h108);
    ImmSrcD = 3'd5; #1; check("arm_imm_rot", ImmExtD, 32'hFF000000);
    ImmSrcD = 3'd6; #1; check("arm_imm_mem", ImmExtD, 32'h000004FF);
    ImmSrcD = 3'd7; #1; check("arm_imm_br", ImmExtD, 32'hFE3C13FC);
    // ARM r0 is writable: read via Rm=0
    fetch(32'hE0810000, 32'h108); step();
    RegWriteW = 1'b1; armW = 1'b1; RdW = 5'd0; ResultW = 32'h00000777; step();
    RegWriteW = 1'b0; armW = 1'b0; #1;
    check("arm_r0", RD2D, 32'h00000777);
    armD = 1'b0;
`else
    // ARM disabled: armD ignored, stored r15 returned, ARM immediates are zero
    armD = 1'b1; #1;
    check("noarm_rs1", {27'h0, Rs1D}, 32'd15);
    check("noarm_r15", RD1D, 32'hCAFE0000);
    ImmSrcD = 3'd5; #1; check("noarm_imm5", ImmExtD, 32'h0);
    ImmSrcD = 3'd7; #1; check("noarm_imm7", ImmExtD, 32'h0);
    armD = 1'b0;
`endif

    // Reset mid-stall with a pending write; stall resumes afterwards
    ImmSrcD = 3'd0;
    fetch(32'h004182B3, 32'h90); StallD = 1'b0; step();
    StallD = 1'b1; rst = 1'b1;
    RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'h55;
    step();
    check("rst2_instr", InstrD, 32'h00000013);
    check("rst2_valid", {31'h0, ValidD}, 32'h0);
    rst = 1'b0; RegWriteW = 1'b0;
    step();
    check("rst2_stall_hold", InstrD, 32'h00000013);
    StallD = 1'b0; step();
    check("rst2_reload", InstrD, 32'h004182B3);
    check("rst2_x3_clear", RD1D, 32'h0);
    check("rst2_x4_clear", RD2D, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_d.md
STAGE_D -- requirements
Module: stage_d

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port RDD  input  32  instruction word from fetch program memory.
REQ-004 SHALL have port PCF  input  32  fetch PC.
REQ-005 SHALL have port PCPlus4F  input  32  fetch PC+4.
REQ-006 SHALL have ports StallD, FlushD  input  1 each  hazard-unit controls.
REQ-007 SHALL have port armD  input  1  instruction in decode is ARM (1) or RV (0).
REQ-008 SHALL have port ImmSrcD  input  3  immediate format from controller: RV I/S/B/U/J = 0..4; ARM DP-rot/MEM12/BR24 = 5..7.
REQ-009 SHALL have ports RegWriteW, armW  input  1 each; RdW  input  5; ResultW  input  32  writeback port.
REQ-010 SHALL have ports InstrD, PCD, PCPlus4D  output  32  IF/ID register contents.
REQ-011 SHALL have ports RD1D, RD2D, ImmExtD  output  32; Rs1D, Rs2D, RdD  output  5; ValidD  output  1.

Function
REQ-012 IF/ID register SHALL capture RDD, PCF, PCPlus4F each edge when StallD=0 and FlushD=0; ValidD<=1.
REQ-013 StallD=1, FlushD=0 SHALL hold all IF/ID contents unchanged.
REQ-014 FlushD=1 SHALL load InstrD=32'h00000013 (NOP), PCD=0, PCPlus4D=0, ValidD=0, regardless of StallD (flush has priority).
REQ-015 RV mode (armD=0): Rs1D=InstrD[19:15], Rs2D=InstrD[24:20], RdD=InstrD[11:7].
REQ-016 ARM mode: Rs1D={1'b0,InstrD[19:16]} (Rn), Rs2D={1'b0,InstrD[3:0]} (Rm), RdD={1'b0,InstrD[15:12]}.
REQ-017 Register file: 32x32, two combinational read ports, one write port, written on rising edge when RegWriteW=1.
REQ-018 Writes with RdW=0 and armW=0 SHALL be discarded; reads of index 0 with armD=0 SHALL return 0.
REQ-019 Read of index 15 with armD=1 SHALL return PCPlus4D+4 (PC+8), not the stored value.
REQ-020 Write-through: if RegWriteW=1 and RdW equals a read index in the same cycle, that port SHALL return ResultW (subject to REQ-018/019 overrides).
REQ-021 ImmExtD SHALL be combinational from InstrD and ImmSrcD: RV I/S/B/U/J per RV32I sign-extension; 5: zero-extended InstrD[7:0] rotated right by 2*InstrD[11:8]; 6: zero-extended InstrD[11:0]; 7: sign-extended {InstrD[23:0],2'b00}.
REQ-022 ImmSrcD encodings unused (none) or out of range SHALL yield ImmExtD=0.
REQ-023 Decode outputs SHALL have zero added latency relative to IF/ID contents; IF/ID adds exactly one cycle from fetch.

Reset
REQ-024 rst=1 SHALL set InstrD=NOP, PCD=0, PCPlus4D=0, ValidD=0 and all 32 registers to 0; rst overrides FlushD, StallD and RegWriteW.
REQ-025 Reset asserted mid-stall SHALL clear state on the next edge; stall resumes only after deassertion.

Configuration
REQ-026 Macro COMBI_ARM_EN: defined -> full ARM support per REQ-016/019 and ImmSrcD 5..7; undefined -> armD and armW ignored (treated 0), ARM immediate/PC+8 logic absent, ImmSrcD 5..7 yield 0.

Structure
REQ-027 Shared package combi_pkg SHALL hold the ImmSrc enum (IMM_I..IMM_BR24), NOP_INSTR constant, ARM_PC_IDX=15.
REQ-028 Register file SHALL be a sub-module named regfile; IF/ID register and immediate extender live in stage_d.

Verification
REQ-029 Reset, then RDD=32'h00500093 (addi x1,x0,5), PCF=0x40 -> next cycle InstrD=0x00500093, PCD=0x40, ValidD=1, Rs1D=0, RdD=1, ImmExtD=5.
REQ-030 StallD=1 two cycles while RDD changes -> InstrD/PCD unchanged; StallD=1 with FlushD=1 -> InstrD=0x00000013, ValidD=0.
REQ-031 RegWriteW=1, RdW=3, ResultW=0xDEADBEEF while InstrD reads x3 -> RD1D=0xDEADBEEF same cycle; RdW=0, armW=0 -> x0 still reads 0.
REQ-032 ARM (COMBI_ARM_EN): armD=1, Rn=15, PCPlus4D=0x104 -> RD1D=0x108; InstrD[11:0]=0x4FF, ImmSrcD=5 -> ImmExtD=0xFF000000.
REQ-033 RV B-type beq with offset -4 (InstrD=0xFE000EE3), ImmSrcD=2 -> ImmExtD=0xFFFFFFFC; J-type offset +2048, ImmSrcD=4 -> ImmExtD=0x00000800.
REQ-034 Without COMBI_ARM_EN: armD=1, read index 15 -> stored register value returned; ImmSrcD=5 -> ImmExtD=0.
